reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin write arbiter that shares one WIDTH-bit storage register among N_REQ requesters. Each requester raises a request with its write data; the arbiter grants one requester at a time, captures the granted data into the shared register, and optionally lets a requester lock the register for a bounded burst. It sits between the requester blocks and the single registered datapath they contend for, and is the only writer of that register.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, data/register width
- MAX_HOLD, 4, max consecutive granted cycles per grant, including the first (≥1)
- OW = clog2(N_REQ), derived, owner index width

- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset, sampled on posedge clk
- req  in  N_REQ  per-requester write request
- lock  in  N_REQ  per-requester burst-lock request, meaningful only with req
- wdata  in  N_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- gnt  out  N_REQ  registered one-hot grant, or all zero
- owner  out  OW  index of current/last granted requester
- q  out  WIDTH  shared register contents
- q_valid  out  1  one-cycle pulse: q was written at the last edge

## Operation
- Reset values: gnt=0, owner=0, q=0, q_valid=0, state=IDLE, hold_cnt=0, rr pointer = N_REQ-1, so requester 0 wins first.
- States:
  - IDLE: no grant.
  - GRANT: first granted cycle.
  - LOCK: further locked cycles.
- Arbitration: search starts at (last owner + 1) mod N_REQ and wraps. The owner that just released is searched last.
- IDLE: if |req, then gnt ← onehot(winner), owner ← winner, hold_cnt ← 1, go to GRANT. Else stay.
- GRANT/LOCK, at each edge:
  - If req[owner]=1: q ← wdata[owner] and q_valid ← 1.
  - If req[owner]=0: no write, q_valid ← 0, release.
- Continue (go to LOCK, hold_cnt+1) iff req[owner] & lock[owner] & hold_cnt < MAX_HOLD.
- Release in all other cases:
  - Another request pending: re-arbitrate at the same edge; the new gnt takes effect next cycle with no idle bubble.
  - No request pending: gnt ← 0, go to IDLE.
- The releasing owner may win again only if no other req is high.
- lock asserted by a non-owner is ignored. A lock dropped mid-burst releases at that edge.
- gnt is one-hot or zero at all times; q changes only in a granted cycle with req[owner]=1.

## Timing
- req high before edge k with arbiter IDLE: gnt high in cycle k..k+1; q updated and q_valid=1 after edge k+1. Request-to-data latency is 2 edges.
- Back-to-back requesters without lock: one grant and one write per cycle, full throughput.
- A locked burst occupies exactly min(MAX_HOLD, cycles with req&lock held) granted cycles.
- rst wins over every other event in the same cycle:
  - Outputs return to their reset values at that edge, including mid-burst.
  - The in-flight write is discarded.
  - The pointer returns to N_REQ-1.
- wdata is sampled only at the writing edge; it need not be stable in other cycles.

## Structure
- Package reg_arb_pkg:
  - state enum {IDLE, GRANT, LOCK}.
  - Default constants N_REQ_DEF=4, WIDTH_DEF=8, MAX_HOLD_DEF=4.
  - Function onehot(idx).
- Sub-module rr_pick: combinational, takes req[N_REQ] and start index; outputs found and winner index. Shared by the IDLE and release paths.
- Top holds the FSM, hold_cnt (width clog2(MAX_HOLD+1)), owner/pointer, gnt, q and q_valid registers.

## Test plan
- Reset: hold rst 2 cycles with random req/wdata. Expect gnt=0, q=0, q_valid=0, owner=0 throughout and on the first cycle after release.
- Single request: req=0001, wdata0=0x5A. Expect gnt=0001 the next cycle, q=0x5A with a q_valid pulse one edge later, then gnt=0.
- Fairness: req=1111 held, no lock, wdata i=0x10+i. Expect gnt order 0,1,2,3,0 on consecutive cycles and q sequence 0x10,0x11,0x12,0x13,0x10.
- Lock bound:
  - Stimulus: MAX_HOLD=4, req1+lock1 held, req2 high.
  - Expect gnt=0010 for exactly 4 cycles with 4 q_valid pulses, then gnt=0100 immediately after.
- Dropped request: req3 removed in its granted cycle. Expect q unchanged, q_valid=0, and a release to the next requester or IDLE.
- Mid-burst reset: rst asserted during the 2nd locked cycle of requester 2.
  - Expect all outputs reset at that edge.
  - With req=0110 afterwards, the first grant goes to requester 1.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types, default parameters and helpers for reg_write_arbiter
package reg_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;
    localparam int N_REQ_DEF    = 4;
    localparam int WIDTH_DEF    = 8;
    localparam int MAX_HOLD_DEF = 4;
    function automatic logic [7:0] onehot(input logic [2:0] idx);
        onehot = 8'd1 << idx;
    endfunction
endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search from a start index, wrapping
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int OW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    start,
    output logic             found,
    output logic [OW-1:0]    winner
);
    int idx;
    // scan farthest offset first so the nearest requester after start overrides
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N_REQ;
            if (req[idx]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter owning one shared register with bounded lock bursts
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int OW       = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [OW-1:0]          owner,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t             state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [OW-1:0]      owner_q, owner_d, ptr_q, ptr_d, start, winner;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q_valid_q, q_valid_d, found, own_req, own_lock;

    // the previous owner sits last in the search order
    assign start = (ptr_q == OW'(N_REQ - 1)) ? '0 : ptr_q + 1'b1;

    rr_pick #(.N_REQ(N_REQ), .OW(OW)) u_pick (
        .req    (req),
        .start  (start),
        .found  (found),
        .winner (winner)
    );

    // next-state: write the owner's data, extend a locked burst, or re-arbitrate with no bubble
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        own_req   = req[owner_q];
        own_lock  = lock[owner_q];
        if (state_q != IDLE && own_req) begin
            q_d       = wdata[int'(owner_q)*WIDTH +: WIDTH];
            q_valid_d = 1'b1;
        end
        if (state_q != IDLE && own_req && own_lock && hold_q < HW'(MAX_HOLD)) begin
            state_d = LOCK;
            hold_d  = hold_q + 1'b1;
        end else if (found) begin
            state_d = GRANT;
            hold_d  = HW'(1);
            owner_d = winner;
            ptr_d   = winner;
            gnt_d   = N_REQ'(onehot(3'(winner)));
        end else begin
            state_d = IDLE;
            hold_d  = '0;
            gnt_d   = '0;
        end
    end

    // state registers; reset discards any in-flight write and rewinds the pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            owner_q   <= '0;
            ptr_q     <= OW'(N_REQ - 1);
            gnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: scenario tasks with a write scoreboard for reg_write_arbiter
module tb_reg_write_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  lock = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  q;
    logic        q_valid;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_v;
    int          checks = 0;
    int          errors = 0;

    reg_write_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .owner   (owner),
        .q       (q),
        .q_valid (q_valid)
    );

    always #5 clk = ~clk;

    // every q_valid pulse must match the next expected write
    always @(negedge clk) begin
        if (q_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write got q=%h exp no write", q);
            end else begin
                exp_v = exp_q.pop_front();
                if (q !== exp_v) begin
                    errors++;
                    $display("FAIL sb_write_data got %h exp %h", q, exp_v);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input int i, input logic [7:0] v);
        wdata[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; lock = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic sb_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_drain got %0d pending exp 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            req = 4'($urandom); lock = 4'($urandom); wdata = $urandom;
            step();
            checks++;
            if ({gnt, owner, q, q_valid} !== 15'd0) begin
                errors++;
                $display("FAIL reset_hold got gnt=%b owner=%0d q=%h qv=%b exp all zero", gnt, owner, q, q_valid);
            end
        end
        rst = 1'b0; req = '0; lock = '0;
        step();
        checks++;
        if ({gnt, owner, q, q_valid} !== 15'd0) begin
            errors++;
            $display("FAIL reset_release got gnt=%b owner=%0d q=%h qv=%b exp all zero", gnt, owner, q, q_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; set_wd(0, 8'h5A); exp_q.push_back(8'h5A);
        step();
        checks++;
        if (gnt !== 4'b0001 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_grant got gnt=%b qv=%b exp 0001 0", gnt, q_valid);
        end
        step();
        checks++;
        if (q !== 8'h5A || q_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_write got q=%h qv=%b exp 5a 1", q, q_valid);
        end
        req = '0;
        step();
        checks++;
        if (gnt !== 4'b0000 || q_valid !== 1'b0 || q !== 8'h5A) begin
            errors++;
            $display("FAIL single_idle got gnt=%b qv=%b q=%h exp 0000 0 5a", gnt, q_valid, q);
        end
        sb_drained("single");
    endtask

    task automatic test_fairness();
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_wd(i, 8'(8'h10 + i));
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h10 + (i % 4)));
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (gnt !== 4'(4'b0001 << (i % 4)) || owner !== 2'(i % 4)) begin
                errors++;
                $display("FAIL fair_order[%0d] got gnt=%b owner=%0d exp %b %0d", i, gnt, owner, 4'(4'b0001 << (i % 4)), i % 4);
            end
        end
        step();
        checks++;
        if (gnt !== 4'b0010 || q !== 8'h10) begin
            errors++;
            $display("FAIL fair_wrap got gnt=%b q=%h exp 0010 10", gnt, q);
        end
        req = '0;
        step();
        checks++;
        if (gnt !== 4'b0000 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL fair_idle got gnt=%b qv=%b exp 0000 0", gnt, q_valid);
        end
        sb_drained("fair");
    endtask

    task automatic test_lock_bound();
        do_reset();
        req = 4'b0110; lock = 4'b0110 & 4'b0010; set_wd(1, 8'h20); set_wd(2, 8'h33);
        step();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL lock_first got gnt=%b exp 0010", gnt);
        end
        for (int c = 0; c < 4; c++) begin
            set_wd(1, 8'(8'h20 + c)); exp_q.push_back(8'(8'h20 + c));
            step();
            checks++;
            if (q_valid !== 1'b1 || gnt !== (c < 3 ? 4'b0010 : 4'b0100)) begin
                errors++;
                $display("FAIL lock_burst[%0d] got gnt=%b qv=%b exp %b 1", c, gnt, q_valid, (c < 3 ? 4'b0010 : 4'b0100));
            end
        end
        exp_q.push_back(8'h33);
        step();
        checks++;
        if (gnt !== 4'b0010 || q !== 8'h33) begin
            errors++;
            $display("FAIL lock_next got gnt=%b q=%h exp 0010 33", gnt, q);
        end
        req = '0; lock = '0;
        step();
        checks++;
        if (gnt !== 4'b0000 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL lock_idle got gnt=%b qv=%b exp 0000 0", gnt, q_valid);
        end
        sb_drained("lock");
    endtask

    task automatic test_dropped();
        do_reset();
        req = 4'b1000; set_wd(3, 8'h77); set_wd(2, 8'h44);
        step();
        checks++;
        if (gnt !== 4'b1000 || owner !== 2'd3) begin
            errors++;
            $display("FAIL drop_grant got gnt=%b owner=%0d exp 1000 3", gnt, owner);
        end
        req = 4'b0100;
        step();
        checks++;
        if (q !== 8'h00 || q_valid !== 1'b0 || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL drop_release got q=%h qv=%b gnt=%b exp 00 0 0100", q, q_valid, gnt);
        end
        req = '0;
        step();
        checks++;
        if (q !== 8'h00 || q_valid !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL drop_idle got q=%h qv=%b gnt=%b exp 00 0 0000", q, q_valid, gnt);
        end
        sb_drained("drop");
    endtask

    task automatic test_mid_burst_reset();
        do_reset();
        req = 4'b0100; lock = 4'b0100; set_wd(2, 8'h55);
        step();
        exp_q.push_back(8'h55);
        step();
        set_wd(2, 8'h56); exp_q.push_back(8'h56);
        step();
        checks++;
        if (gnt !== 4'b0100 || q !== 8'h56) begin
            errors++;
            $display("FAIL mrst_burst got gnt=%b q=%h exp 0100 56", gnt, q);
        end
        rst = 1'b1; set_wd(2, 8'h66);
        step();
        checks++;
        if ({gnt, owner, q, q_valid} !== 15'd0) begin
            errors++;
            $display("FAIL mrst_reset got gnt=%b owner=%0d q=%h qv=%b exp all zero", gnt, owner, q, q_valid);
        end
        rst = 1'b0; lock = '0; req = 4'b0110; set_wd(1, 8'h21);
        step();
        checks++;
        if (gnt !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("FAIL mrst_regrant got gnt=%b owner=%0d exp 0010 1", gnt, owner);
        end
        req = 4'b0010; exp_q.push_back(8'h21);
        step();
        checks++;
        if (q !== 8'h21 || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL mrst_write got q=%h gnt=%b exp 21 0010", q, gnt);
        end
        req = '0;
        step();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL mrst_idle got gnt=%b exp 0000", gnt);
        end
        sb_drained("mrst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_lock_bound();
        test_dropped();
        test_mid_burst_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
